reg_file_access_ctrl: RTL and testbench

- Sequential access agent that drives the register heap's ports from the outside. It serves the debug/loader path, not the CPU datapath.
- Dump mode: walks the read address over a register range, captures each word, and streams (addr, data) out on a valid/ready interface toward display/UART logic.
- Load mode: accepts words on a valid/ready input and issues write-port pulses to fill a register range.
- `busy` stalls the CPU while the top level muxes this block onto the heap ports.

---
 rtl/reg_file_access_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_reg_file_access_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_access_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_access_ctrl
//
// Debug/loader agent that takes over the register heap's ports from outside
// the CPU datapath.
//   * Dump: walks the heap read address from FIRST_REG to LAST_REG, captures
//     each word and offers (addr, data) on a valid/ready output stream.
//   * Load: accepts words on a valid/ready input stream and issues one heap
//     write pulse per accepted word, filling LOAD_FIRST..LAST_REG.
//   * busy tells the top level to stall the CPU and mux this block onto the
//     heap ports; done pulses for one cycle when an operation finishes.
//
// Ports
//   clk_Regs     in   clock shared with the register heap
//   rst_n        in   asynchronous active-low reset
//   start_dump   in   level, sampled in IDLE, starts a dump (wins over load)
//   start_load   in   level, sampled in IDLE, starts a load
//   reg_addr     out  heap read address (always equals the walk pointer)
//   reg_data_in  in   heap read data, combinational from reg_addr
//   reg_write    out  heap write enable
//   w_addr       out  heap write address
//   w_data       out  heap write data
//   out_valid    out  dump word valid
//   out_ready    in   dump consumer ready
//   out_addr     out  register index of the dump word
//   out_data     out  dump word
//   in_valid     in   load word valid
//   in_ready     out  load word accepted (combinational, high in LOAD)
//   in_data      in   load word
//   busy         out  high while dumping or loading
//   done         out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module reg_file_access_ctrl #(
    parameter int unsigned FIRST_REG  = 0,
    parameter int unsigned LAST_REG   = 31,
    parameter int unsigned LOAD_FIRST = 1
) (
    input  logic        clk_Regs,
    input  logic        rst_n,
    input  logic        start_dump,
    input  logic        start_load,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data_in,
    output logic        reg_write,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DUMP_RD = 3'd1,
        ST_DUMP_TX = 3'd2,
        ST_LOAD    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [4:0] FIRST_PTR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_PTR  = 5'(LAST_REG);
    localparam logic [4:0] LOAD_PTR  = 5'(LOAD_FIRST);

    state_t      state_q,     state_d;
    logic [4:0]  ptr_q,       ptr_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  w_addr_q,    w_addr_d;
    logic [31:0] w_data_q,    w_data_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_addr_q,  out_addr_d;
    logic [31:0] out_data_q,  out_data_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        reg_write_d = reg_write_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                reg_write_d = 1'b0;
                // Dump has priority when both starts are seen together.
                if (start_dump) begin
                    ptr_d   = FIRST_PTR;
                    state_d = ST_DUMP_RD;
                end else if (start_load) begin
                    ptr_d   = LOAD_PTR;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DUMP_RD: begin
                // Heap read data is combinational on reg_addr (= ptr), so it
                // is already valid in this cycle.
                out_data_d  = reg_data_in;
                out_addr_d  = ptr_q;
                out_valid_d = 1'b1;
                state_d     = ST_DUMP_TX;
            end

            ST_DUMP_TX: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (ptr_q == LAST_PTR) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        state_d = ST_DUMP_RD;
                    end
                end else begin
                    state_d = ST_DUMP_TX;
                end
            end

            ST_LOAD: begin
                // in_ready is high for the whole LOAD state, so in_valid alone
                // marks an accept.
                if (in_valid) begin
                    reg_write_d = 1'b1;
                    w_addr_d    = ptr_q;
                    w_data_d    = in_data;
                    if (ptr_q == LAST_PTR) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    reg_write_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end

            ST_DONE: begin
                // The final load write pulse is still high during DONE; it
                // ends here. ptr is kept for inspection until the next start.
                reg_write_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                reg_write_d = 1'b0;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DUMP_RD) || (state_d == ST_DUMP_TX) ||
                 (state_d == ST_LOAD);
    end

    // State and registered-output flops; reset aborts any operation at once.
    always_ff @(posedge clk_Regs or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 5'd0;
            reg_write_q <= 1'b0;
            w_addr_q    <= 5'd0;
            w_data_q    <= 32'd0;
            out_valid_q <= 1'b0;
            out_addr_q  <= 5'd0;
            out_data_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            reg_write_q <= reg_write_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign reg_addr  = ptr_q;
    assign reg_write = reg_write_q;
    assign w_addr    = w_addr_q;
    assign w_data    = w_data_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = (state_q == ST_LOAD);

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for reg_file_access_ctrl. Surrounds the block with a simple
// register heap (x0 reads zero, cleared by rst_n) and runs a table of dump and
// load scenarios, checking per-word contents, cycle counts and write counts.
// -----------------------------------------------------------------------------
module tb_reg_file_access_ctrl;

    logic        clk_Regs = 1'b0;
    logic        rst_n;
    logic        start_dump, start_load;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data_in;
    logic        reg_write;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        busy, done;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;

    logic [31:0] heap    [32];
    logic [31:0] exp_mem [32];

    always #5 clk_Regs = ~clk_Regs;

    reg_file_access_ctrl dut (
        .clk_Regs   (clk_Regs),
        .rst_n      (rst_n),
        .start_dump (start_dump),
        .start_load (start_load),
        .reg_addr   (reg_addr),
        .reg_data_in(reg_data_in),
        .reg_write  (reg_write),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .busy       (busy),
        .done       (done)
    );

    // Register heap environment: commits on the edge where reg_write is high.
    always @(posedge clk_Regs or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) heap[i] <= 32'd0;
        end else if (reg_write && (w_addr != 5'd0)) begin
            heap[w_addr] <= w_data;
        end
    end

    assign reg_data_in = heap[reg_addr];

    // Count clock edges that see a write pulse.
    always @(posedge clk_Regs) begin
        if (reg_write === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    typedef struct {
        bit          is_load;
        int          stall_idx;
        int          stall_len;
        bit          gap;
        bit          both;
        int          abort_after;
        logic [31:0] base;
        int          exp_cycles;
        int          exp_wr;
    } row_t;

    row_t rows [7];

    task automatic step();
        @(posedge clk_Regs);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_dump(input row_t r, output int cyc);
        logic [31:0] held;
        int          n;
        start_dump = 1'b1;
        start_load = r.both;
        out_ready  = 1'b1;
        step();
        start_dump = 1'b0;
        start_load = 1'b0;
        cyc = 0;
        chk("dump_busy_start", {31'd0, busy}, 32'd1);
        chk("dump_no_inready", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 32; k++) begin
            if (r.both && k == 5) start_load = 1'b1;
            n = 0;
            while (out_valid !== 1'b1 && n < 10) begin
                step();
                cyc++;
                n++;
            end
            if (out_valid !== 1'b1) begin
                chk("dump_valid_timeout", {31'd0, out_valid}, 32'd1);
                return;
            end
            chk("dump_addr", {27'd0, out_addr}, k);
            chk("dump_data", out_data, exp_mem[k]);
            if (k == r.stall_idx) begin
                out_ready = 1'b0;
                held = out_data;
                for (int s = 0; s < r.stall_len; s++) begin
                    step();
                    cyc++;
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_addr", {27'd0, out_addr}, k);
                    chk("stall_data", out_data, held);
                end
                out_ready = 1'b1;
            end
            step();
            cyc++;
            start_load = 1'b0;
            if (k < 31) chk("dump_valid_drop", {31'd0, out_valid}, 32'd0);
        end
        chk("dump_done", {31'd0, done}, 32'd1);
        chk("dump_busy_end", {31'd0, busy}, 32'd0);
        step();
        chk("dump_done_once", {31'd0, done}, 32'd0);
        chk("dump_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_load(input row_t r, output int cyc);
        int acc;
        logic iv;
        start_load = 1'b1;
        step();
        start_load = 1'b0;
        cyc = 0;
        acc = 0;
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_ptr0", {27'd0, reg_addr}, 32'd1);
        while (acc < 31 && cyc < 200) begin
            iv = r.gap ? ((cyc % 3) == 0) : 1'b1;
            in_valid = iv;
            in_data  = iv ? r.base + 32'(acc + 1) : 32'd0;
            chk("load_inready", {31'd0, in_ready}, 32'd1);
            step();
            cyc++;
            if (iv) begin
                acc++;
                chk("load_wr", {31'd0, reg_write}, 32'd1);
                chk("load_waddr", {27'd0, w_addr}, acc);
                chk("load_wdata", w_data, r.base + 32'(acc));
            end else begin
                chk("load_gap_wr", {31'd0, reg_write}, 32'd0);
                chk("load_gap_ptr", {27'd0, reg_addr}, acc + 1);
            end
            if (r.abort_after != 0 && acc == r.abort_after) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("abort_wr", {31'd0, reg_write}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_inready", {31'd0, in_ready}, 32'd0);
                chk("abort_ptr", {27'd0, reg_addr}, 32'd0);
                step();
                step();
                rst_n = 1'b1;
                step();
                chk("abort_stays_idle", {31'd0, in_ready}, 32'd0);
                for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_last_wr", {31'd0, reg_write}, 32'd1);
        chk("load_last_waddr", {27'd0, w_addr}, 32'd31);
        chk("load_done_inready", {31'd0, in_ready}, 32'd0);
        step();
        chk("load_done_once", {31'd0, done}, 32'd0);
        chk("load_wr_end", {31'd0, reg_write}, 32'd0);
        exp_mem[0] = 32'd0;
        for (int i = 1; i < 32; i++) exp_mem[i] = r.base + 32'(i);
    endtask

    initial begin
        int cyc;
        int wr0;

        // {is_load, stall_idx, stall_len, gap, both, abort_after, base, exp_cycles, exp_wr}
        rows[0] = '{1'b0, -1, 0, 1'b0, 1'b0, 0, 32'h0,         64, 0};
        rows[1] = '{1'b1, -1, 0, 1'b0, 1'b0, 0, 32'h1000_0000, 31, 31};
        rows[2] = '{1'b0,  3, 5, 1'b0, 1'b0, 0, 32'h0,         69, 0};
        rows[3] = '{1'b1, -1, 0, 1'b1, 1'b0, 0, 32'h2000_0000, 91, 31};
        rows[4] = '{1'b0, -1, 0, 1'b0, 1'b1, 0, 32'h0,         64, 0};
        rows[5] = '{1'b1, -1, 0, 1'b0, 1'b0, 10, 32'h3000_0000, 10, 9};
        rows[6] = '{1'b0, -1, 0, 1'b0, 1'b0, 0, 32'h0,         64, 0};

        for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;

        rst_n      = 1'b0;
        start_dump = 1'b0;
        start_load = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        step();
        step();
        chk("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_w_addr", {27'd0, w_addr}, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_addr", {27'd0, out_addr}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int t = 0; t < 7; t++) begin
            wr0 = wr_cnt;
            if (rows[t].is_load) run_load(rows[t], cyc);
            else                 run_dump(rows[t], cyc);
            chk($sformatf("row%0d_cycles", t), cyc, rows[t].exp_cycles);
            chk($sformatf("row%0d_writes", t), wr_cnt - wr0, rows[t].exp_wr);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
